// File: rtl/dump_pkg.sv
// dump_pkg: state encoding and power-up dump defaults shared with the sequence controller
package dump_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ON, S_GAP} dump_state_e;
    localparam int DUMP_DEF_DELAY = 0;
    localparam int DUMP_DEF_WIDTH = 19;
endpackage

// File: rtl/dump_cnt.sv
// dump_cnt: loadable down-counter that stops at 1, with a registered last flag
//   clk, reset  : clock, synchronous active-low reset
//   load_i      : load val_i (takes priority over en_i)
//   en_i        : decrement while above 1
//   val_i       : load value, caller guarantees >= 1
//   last_o      : registered, high while the count is 1
module dump_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            last_o <= 1'b0;
        end else if (load_i) begin
            cnt_q  <= val_i;
            last_o <= val_i == CNT_W'(1);
        end else if (en_i && cnt_q > CNT_W'(1)) begin
            cnt_q  <= cnt_q - CNT_W'(1);
            last_o <= cnt_q == CNT_W'(2);
        end
    end
endmodule

// File: rtl/dump_pulse_seq.sv
// dump_pulse_seq: receiver-protection / ring-down dump pulse burst generator
//   clk, reset           : clock, synchronous active-low reset
//   trig, abort          : start request (IDLE only), kill burst
//   cfg_delay/width/gap  : burst timing in cycles (width/gap 0 -> 1), latched at start
//   cfg_repeat           : extra pulses after the first
//   dumpon               : registered dump switch drive
//   busy, done           : burst in progress, 1-cycle normal completion strobe
//   trig_drop            : 1-cycle strobe for a trig ignored outside IDLE
//   pulse_idx            : 0-based index of the current or most recent pulse
module dump_pulse_seq import dump_pkg::*; #(
    parameter int CNT_W      = 8,
    parameter int REP_W      = 4,
    parameter int AUTO_START = 1,
    parameter int DEF_DELAY  = DUMP_DEF_DELAY,
    parameter int DEF_WIDTH  = DUMP_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic             dumpon,
    output logic             busy,
    output logic             done,
    output logic             trig_drop,
    output logic [REP_W-1:0] pulse_idx
);
    dump_state_e state_q, state_d;
    logic [CNT_W-1:0] dly_q, dly_d, wid_q, wid_d, gap_q, gap_d, cnt_val;
    logic [REP_W-1:0] rep_q, rep_d, idx_q, idx_d;
    logic arm_q, arm_d, auto_q, dumpon_q, dumpon_d, done_q, done_d, drop_q, drop_d;
    logic cnt_load, cnt_last, idle;

    dump_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (cnt_load),
        .en_i   (!idle),
        .val_i  (cnt_val),
        .last_o (cnt_last)
    );

    // arm_q marks the fixed first DELAY cycle, after which the programmed delay is loaded
    always_comb begin
        idle     = state_q == S_IDLE;
        state_d  = state_q;
        dly_d    = dly_q;
        wid_d    = wid_q;
        gap_d    = gap_q;
        rep_d    = rep_q;
        idx_d    = idx_q;
        arm_d    = arm_q;
        dumpon_d = dumpon_q;
        done_d   = 1'b0;
        drop_d   = trig && !idle;
        cnt_load = 1'b0;
        cnt_val  = CNT_W'(1);
        if (idle && (auto_q || (trig && !abort))) begin
            state_d  = S_DELAY;
            arm_d    = 1'b1;
            idx_d    = '0;
            cnt_load = 1'b1;
            dly_d    = auto_q ? CNT_W'(DEF_DELAY) : cfg_delay;
            wid_d    = auto_q ? CNT_W'(DEF_WIDTH == 0 ? 1 : DEF_WIDTH)
                              : (cfg_width == '0 ? CNT_W'(1) : cfg_width);
            gap_d    = auto_q ? CNT_W'(1) : (cfg_gap == '0 ? CNT_W'(1) : cfg_gap);
            rep_d    = auto_q ? '0 : cfg_repeat;
        end else if (!idle && abort) begin
            state_d  = S_IDLE;
            dumpon_d = 1'b0;
        end else if (state_q == S_DELAY && cnt_last) begin
            arm_d    = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = (arm_q && dly_q != '0) ? dly_q : wid_q;
            state_d  = (arm_q && dly_q != '0) ? S_DELAY : S_ON;
            dumpon_d = !(arm_q && dly_q != '0);
        end else if (state_q == S_ON && cnt_last) begin
            dumpon_d = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = gap_q;
            state_d  = idx_q == rep_q ? S_IDLE : S_GAP;
            done_d   = idx_q == rep_q;
        end else if (state_q == S_GAP && cnt_last) begin
            state_d  = S_ON;
            dumpon_d = 1'b1;
            idx_d    = idx_q + REP_W'(1);
            cnt_load = 1'b1;
            cnt_val  = wid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            dly_q    <= '0;
            wid_q    <= '0;
            gap_q    <= '0;
            rep_q    <= '0;
            idx_q    <= '0;
            arm_q    <= 1'b0;
            auto_q   <= AUTO_START != 0;
            dumpon_q <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            wid_q    <= wid_d;
            gap_q    <= gap_d;
            rep_q    <= rep_d;
            idx_q    <= idx_d;
            arm_q    <= arm_d;
            auto_q   <= 1'b0;
            dumpon_q <= dumpon_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign dumpon    = dumpon_q;
    assign busy      = !idle;
    assign done      = done_q;
    assign trig_drop = drop_q;
    assign pulse_idx = idx_q;
endmodule

// File: tb/tb_dump_pulse_seq.sv
// tb_dump_pulse_seq: schedule-model and directed checks for dump_pulse_seq
module tb_dump_pulse_seq;
    logic clk = 1'b0;
    logic reset = 1'b0, trig = 1'b0, abort = 1'b0;
    logic [7:0] cfg_delay = '0, cfg_width = '0, cfg_gap = '0;
    logic [3:0] cfg_repeat = '0;
    logic dumpon, busy, done, trig_drop;
    logic [3:0] pulse_idx;

    dump_pulse_seq dut (
        .clk(clk), .reset(reset), .trig(trig), .abort(abort),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
        .dumpon(dumpon), .busy(busy), .done(done), .trig_drop(trig_drop), .pulse_idx(pulse_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: a burst started at edge t0 is a fixed schedule; pulse k is high on
    // edges [t0+1+D+k*(W+G), that + W), the burst ends on the fall of pulse R.
    bit m_act, m_auto, e_dumpon, e_busy, e_done, e_drop;
    int m_t0, m_d, m_w, m_g, m_r, m_end, m_idx, m_off;

    always @(posedge clk) begin
        cyc++;
        e_done = 1'b0;
        e_drop = 1'b0;
        if (!reset) begin
            m_act = 1'b0; m_auto = 1'b1; m_idx = 0;
        end else begin
            e_drop = trig && m_act;
            if (!m_act) begin
                if (m_auto || (trig && !abort)) begin
                    m_t0 = cyc;
                    m_d = m_auto ? 0 : int'(cfg_delay);
                    m_w = m_auto ? 19 : (cfg_width == 0 ? 1 : int'(cfg_width));
                    m_g = m_auto ? 1 : (cfg_gap == 0 ? 1 : int'(cfg_gap));
                    m_r = m_auto ? 0 : int'(cfg_repeat);
                    m_end = m_t0 + 1 + m_d + (m_r + 1) * m_w + m_r * m_g;
                    m_act = 1'b1; m_idx = 0;
                end
                m_auto = 1'b0;
            end else if (abort) m_act = 1'b0;
            else if (cyc == m_end) begin
                m_act = 1'b0; e_done = 1'b1;
            end
        end
        e_dumpon = 1'b0;
        if (m_act || e_done) begin
            m_off = cyc - (m_t0 + 1 + m_d);
            if (m_off >= 0) begin
                m_idx = m_off / (m_w + m_g);
                e_dumpon = m_act && (m_off % (m_w + m_g)) < m_w;
            end
        end
        e_busy = m_act;
    end

    always @(negedge clk) if (cyc > 0) begin
        chk("m_dumpon", int'(dumpon), int'(e_dumpon));
        chk("m_busy", int'(busy), int'(e_busy));
        chk("m_done", int'(done), int'(e_done));
        chk("m_drop", int'(trig_drop), int'(e_drop));
        chk("m_idx", int'(pulse_idx), m_idx % 16);
    end

    task automatic at(input int n);
        if (cyc > n) begin
            n_bad++;
            $display("FAIL sched: at edge %0d, required %0d", cyc, n);
        end
        while (cyc < n) @(negedge clk);
    endtask

    task automatic go(output int e0);
        trig = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic cfg(input int d, input int w, input int g, input int r);
        cfg_delay = 8'(d); cfg_width = 8'(w); cfg_gap = 8'(g); cfg_repeat = 4'(r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e0, e1, s;
        repeat (3) @(negedge clk);
        chk("rst_dumpon", int'(dumpon), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(pulse_idx), 0);
        // power-up dump
        reset = 1'b1; e0 = cyc + 1;
        at(e0 + 1);  chk("auto_rise", int'(dumpon), 1);
        at(e0 + 19); chk("auto_high", int'(dumpon), 1);
        at(e0 + 20); chk("auto_fall", int'(dumpon), 0); chk("auto_done", int'(done), 1);
        at(e0 + 21); chk("auto_busy", int'(busy), 0);
        // D3 W5 G2 R2 with dropped trig and mid-burst cfg change
        cfg(3, 5, 2, 2); go(e0);
        at(e0 + 3);  chk("b_delay", int'(dumpon), 0); chk("b_busy", int'(busy), 1);
        at(e0 + 4);  chk("b_rise0", int'(dumpon), 1); chk("b_idx0", int'(pulse_idx), 0);
        at(e0 + 5);  trig = 1'b1; cfg_width = 8'd50;
        at(e0 + 6);  trig = 1'b0; chk("b_drop", int'(trig_drop), 1);
        at(e0 + 9);  chk("b_fall0", int'(dumpon), 0);
        at(e0 + 11); chk("b_rise1", int'(dumpon), 1); chk("b_idx1", int'(pulse_idx), 1);
        at(e0 + 18); chk("b_rise2", int'(dumpon), 1); chk("b_idx2", int'(pulse_idx), 2);
        at(e0 + 23); chk("b_done", int'(done), 1); chk("b_fall2", int'(dumpon), 0);
        at(e0 + 24); chk("b_done1", int'(done), 0);
        // minimum and full-scale
        cfg(0, 0, 0, 0); go(e0);
        at(e0 + 1); chk("min_on", int'(dumpon), 1);
        at(e0 + 2); chk("min_off", int'(dumpon), 0); chk("min_done", int'(done), 1);
        at(e0 + 3); cfg(255, 255, 255, 15); go(e1);
        at(e1 + 255);  chk("max_delay", int'(dumpon), 0);
        at(e1 + 256);  chk("max_rise", int'(dumpon), 1);
        at(e1 + 511);  chk("max_fall", int'(dumpon), 0);
        at(e1 + 8160); chk("max_last", int'(dumpon), 1); chk("max_idx", int'(pulse_idx), 15);
        at(e1 + 8161); chk("max_done", int'(done), 1);
        // abort while high, clean restart
        at(e1 + 8163); cfg(3, 5, 2, 2); go(e0);
        at(e0 + 11); chk("ab_high", int'(dumpon), 1); abort = 1'b1;
        at(e0 + 12); abort = 1'b0; trig = 1'b1;
        chk("ab_dumpon", int'(dumpon), 0); chk("ab_busy", int'(busy), 0); chk("ab_done", int'(done), 0);
        e1 = e0 + 13;
        at(e1); trig = 1'b0; chk("ab_restart", int'(busy), 1);
        at(e1 + 4);  chk("ab_rise", int'(dumpon), 1); chk("ab_idx", int'(pulse_idx), 0);
        at(e1 + 23); chk("ab_fin", int'(done), 1);
        at(e1 + 25); trig = 1'b1; abort = 1'b1;
        at(e1 + 26); trig = 1'b0; abort = 1'b0; chk("ab_idle", int'(busy), 0);
        // level-held trig
        cfg(0, 1, 1, 0); s = cyc + 1; trig = 1'b1;
        at(s + 2); chk("lvl_drop", int'(trig_drop), 1); chk("lvl_done", int'(done), 1);
        at(s + 3); chk("lvl_again", int'(busy), 1);
        at(s + 7); trig = 1'b0;
        // reset mid-gap then auto dump again, trig absorbed
        at(s + 12); cfg(3, 5, 2, 2); go(e0);
        at(e0 + 9); reset = 1'b0;
        at(e0 + 10);
        chk("rg_dumpon", int'(dumpon), 0); chk("rg_busy", int'(busy), 0);
        chk("rg_idx", int'(pulse_idx), 0); chk("rg_done", int'(done), 0);
        reset = 1'b1; trig = 1'b1;
        at(e0 + 11); trig = 1'b0; chk("rg_absorb", int'(trig_drop), 0); chk("rg_auto", int'(busy), 1);
        at(e0 + 12); chk("rg_rise", int'(dumpon), 1);
        at(e0 + 31); chk("rg_done2", int'(done), 1);
        at(e0 + 33);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
